// File: rtl/generic_bus_ram_pkg.sv
// Shared types for the generic_bus RAM responder: FSM states, request latch
// and the word-index width helper.
package generic_bus_ram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } responder_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  byte_en;
  } req_latch_t;

  localparam int DEFAULT_DEPTH = 4096;
  localparam int CNT_W         = 4;

  function automatic int index_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/generic_bus_ram_array.sv
// DEPTH x 32 word store split into four byte lanes: synchronous lane-masked
// write, combinational read. Swappable for a vendor BRAM wrapper.
module generic_bus_ram_array #(
  parameter int DEPTH = 4096,
  parameter int IDX_W = 12
) (
  input  logic             CLK,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [31:0]      wdata,
  input  logic [3:0]       byte_en,
  input  logic [IDX_W-1:0] ridx,
  output logic [31:0]      rdata
);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      // One array per lane keeps each write a plain full-width store.
      logic [7:0] lane_mem [DEPTH];

      always_ff @(posedge CLK) begin
        if (we && byte_en[gi]) begin
          lane_mem[widx] <= wdata[8*gi +: 8];
        end
      end

      assign rdata[8*gi +: 8] = lane_mem[ridx];
    end
  endgenerate

endmodule

// File: rtl/generic_bus_ram_responder.sv
// Memory-side generic_bus responder: one word access at a time with LATENCY
// wait states, abort on request change, out-of-range fault reporting.
module generic_bus_ram_responder
  import generic_bus_ram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000,
  parameter int          DEPTH     = DEFAULT_DEPTH,
  parameter int          LATENCY   = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] addr,
  input  logic        ren,
  input  logic        wen,
  input  logic [31:0] wdata,
  input  logic [3:0]  byte_en,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        addr_fault
);

  localparam int          IDX_W = index_width(DEPTH);
  localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;

  responder_state_t state_reg;
  req_latch_t       latch_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [31:0]      rdata_reg;
  logic             busy_reg;
  logic             fault_reg;

  logic             req;
  logic             req_changed;
  logic [31:0]      cur_addr;
  logic             cur_wen;
  logic [32:0]      offset;
  logic             in_range;
  logic [IDX_W-1:0] cur_idx;
  logic [31:0]      array_rdata;
  logic             array_we;
  logic [31:0]      resp_data;

  assign req = ren | wen;

  assign req_changed = (addr    != latch_reg.addr)  ||
                       (wen     != latch_reg.wen)   ||
                       (wdata   != latch_reg.wdata) ||
                       (byte_en != latch_reg.byte_en);

  // In IDLE the live bus is decoded so LATENCY=0 can respond straight away;
  // afterwards the latched request is the one being serviced.
  assign cur_addr = (state_reg == IDLE) ? addr : latch_reg.addr;
  assign cur_wen  = (state_reg == IDLE) ? wen  : latch_reg.wen;

  // 33-bit compare so addresses near 2^32 cannot wrap into the window.
  assign offset   = {1'b0, cur_addr} - {1'b0, BASE_ADDR};
  assign in_range = ({1'b0, cur_addr} >= {1'b0, BASE_ADDR}) && (offset < SPAN);
  assign cur_idx  = offset[IDX_W+1:2];

  assign resp_data = (cur_wen || !in_range) ? 32'h0 : array_rdata;

  // Commit happens on the edge leaving ACK, and never on a reset edge.
  assign array_we = (state_reg == ACK) && latch_reg.wen && in_range && !RST;

  generic_bus_ram_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .CLK     (CLK),
    .we      (array_we),
    .widx    (cur_idx),
    .wdata   (latch_reg.wdata),
    .byte_en (latch_reg.byte_en),
    .ridx    (cur_idx),
    .rdata   (array_rdata)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;
      latch_reg <= '0;
      cnt_reg   <= '0;
      rdata_reg <= '0;
      busy_reg  <= 1'b1;
      fault_reg <= 1'b0;
    end else begin
      busy_reg  <= 1'b1;
      fault_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req) begin
            latch_reg.addr    <= addr;
            latch_reg.wen     <= wen;
            latch_reg.wdata   <= wdata;
            latch_reg.byte_en <= byte_en;
            cnt_reg           <= CNT_W'(LATENCY);
            if (LATENCY == 0) begin
              state_reg <= ACK;
              busy_reg  <= 1'b0;
              fault_reg <= !in_range;
              rdata_reg <= resp_data;
            end else begin
              state_reg <= WAIT;
            end
          end
        end

        WAIT: begin
          cnt_reg <= cnt_reg - CNT_W'(1);
          if (!req || req_changed) begin
            state_reg <= IDLE;
          end else if (cnt_reg == CNT_W'(1)) begin
            state_reg <= ACK;
            busy_reg  <= 1'b0;
            fault_reg <= !in_range;
            rdata_reg <= resp_data;
          end
        end

        ACK: begin
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign rdata      = rdata_reg;
  assign busy       = busy_reg;
  assign addr_fault = fault_reg;

endmodule
